// File: rtl/seq_pkg.sv
// Shared constants, state encoding and instruction field positions for instr_sequencer.
package seq_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_HALT   = 4'd8;

  localparam logic [31:0] NOP_WORD = {OP_NOP, 28'd0};

  // Condition selectors held in CC[2:0]; CC[3] inverts the selected condition
  localparam logic [2:0] CC_ALWAYS = 3'd0;
  localparam logic [2:0] CC_CARRY  = 3'd1;
  localparam logic [2:0] CC_PARITY = 3'd2;
  localparam logic [2:0] CC_EVEN   = 3'd3;
  localparam logic [2:0] CC_NEG    = 3'd4;
  localparam logic [2:0] CC_ODD    = 3'd5;

  localparam int PSR_CARRY  = 0;
  localparam int PSR_PARITY = 1;
  localparam int PSR_EVEN   = 2;
  localparam int PSR_NEG    = 3;
  localparam int PSR_ODD    = 4;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int CC_MSB = 27;
  localparam int CC_LSB = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_EVAL = 2'd2,
    HALTED  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the 5-bit psr to a take decision.
module seq_cond_eval
  import seq_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [4:0] psr,
  output logic       take
);

  logic w_sel;

  always_comb begin
    w_sel = 1'b0;
    case (cc[2:0])
      CC_ALWAYS: w_sel = 1'b1;
      CC_CARRY:  w_sel = psr[PSR_CARRY];
      CC_PARITY: w_sel = psr[PSR_PARITY];
      CC_EVEN:   w_sel = psr[PSR_EVEN];
      CC_NEG:    w_sel = psr[PSR_NEG];
      CC_ODD:    w_sel = psr[PSR_ODD];
      default:   w_sel = 1'b0;
    endcase
    take = w_sel ^ cc[3];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequencing controller: program memory, pc, branch resolution and halt handling.
// Optional single-step control is enabled by defining INSTR_SEQ_SINGLE_STEP_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int DEPTH = 256
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [31:0]     load_data,
  input  logic [4:0]      psr,
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  input  logic            step,
  input  logic            step_mode,
`endif
  output logic [31:0]     instruction,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            halted,
  output logic            branch_taken
);

  logic [31:0]     r_mem [DEPTH];
  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [3:0]      r_cc;
  logic [PC_W-1:0] r_target;

  state_t          w_stateNext;
  logic [PC_W-1:0] w_pcNext;
  logic [31:0]     w_instrNext;
  logic [3:0]      w_ccNext;
  logic [PC_W-1:0] w_targetNext;
  logic [31:0]     w_word;
  logic            w_take;
  logic            w_advance;
  logic            w_memWe;

`ifdef INSTR_SEQ_SINGLE_STEP_EN
  assign w_advance = !step_mode || step;
`else
  assign w_advance = 1'b1;
`endif

  assign w_word  = r_mem[r_pc];
  assign w_memWe = load_en && ((r_state == IDLE) || (r_state == HALTED));

  // Program memory is deliberately left out of reset so a loaded program survives it
  always_ff @(posedge clock) begin
    if (w_memWe) r_mem[load_addr] <= load_data;
  end

  seq_cond_eval u_condEval (
    .cc   (r_cc),
    .psr  (psr),
    .take (w_take)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_instr  <= NOP_WORD;
      r_cc     <= '0;
      r_target <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_pc     <= w_pcNext;
      r_instr  <= w_instrNext;
      r_cc     <= w_ccNext;
      r_target <= w_targetNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_instrNext  = NOP_WORD;
    w_ccNext     = r_cc;
    w_targetNext = r_target;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_pcNext    = start_addr;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (w_advance) begin
          if (w_word[OP_MSB:OP_LSB] == OP_BRANCH) begin
            w_ccNext     = w_word[CC_MSB:CC_LSB];
            w_targetNext = w_word[PC_W-1:0];
            w_stateNext  = BR_EVAL;
          end else if (w_word[OP_MSB:OP_LSB] == OP_HALT) begin
            w_stateNext = HALTED;
          end else begin
            w_instrNext = w_word;
            w_pcNext    = r_pc + PC_W'(1);
          end
        end
      end
      BR_EVAL: begin
        // The inserted NOP leaves psr untouched, so it still reflects the last real instruction
        w_pcNext    = w_take ? r_target : r_pc + PC_W'(1);
        w_stateNext = RUN;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign instruction  = r_instr;
  assign pc           = r_pc;
  assign running      = (r_state == RUN) || (r_state == BR_EVAL);
  assign halted       = (r_state == HALTED);
  assign branch_taken = (r_state == BR_EVAL) && w_take;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; single-step scenario runs when
// INSTR_SEQ_SINGLE_STEP_EN is defined.
module tb_instr_sequencer;

  localparam int PC_W = 8;
  localparam logic [31:0] HALT_W = 32'h8000_0000;

  logic            clock;
  logic            reset;
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            load_en;
  logic [PC_W-1:0] load_addr;
  logic [31:0]     load_data;
  logic [4:0]      psr;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
  logic            step;
  logic            step_mode;
`endif
  logic [31:0]     instruction;
  logic [PC_W-1:0] pc;
  logic            running;
  logic            halted;
  logic            branch_taken;

  int nVectors;
  int nMiscompares;

  instr_sequencer #(.PC_W(PC_W), .DEPTH(256)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .start_addr   (start_addr),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .psr          (psr),
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    .step         (step),
    .step_mode    (step_mode),
`endif
    .instruction  (instruction),
    .pc           (pc),
    .running      (running),
    .halted       (halted),
    .branch_taken (branch_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadWord(input logic [PC_W-1:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic startAt(input logic [PC_W-1:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    if (instruction !== 32'h0) begin $display("[TB] FAIL rst_instr: got %h want %h", instruction, 32'h0); nMiscompares++; end
    nVectors++;
    if (pc !== 8'h00) begin $display("[TB] FAIL rst_pc: got %h want %h", pc, 8'h00); nMiscompares++; end
    nVectors++;
    if ({running, halted, branch_taken} !== 3'b000) begin $display("[TB] FAIL rst_flags: got %b want %b", {running, halted, branch_taken}, 3'b000); nMiscompares++; end
    nVectors++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_linear();
    loadWord(8'd0, 32'h1800_5000);
    loadWord(8'd1, 32'h5800_3000);
    loadWord(8'd2, HALT_W);
    startAt(8'd0);
    if (running !== 1'b1 || instruction !== 32'h0) begin $display("[TB] FAIL lin_start: got run=%b instr=%h want run=1 instr=0", running, instruction); nMiscompares++; end
    nVectors++;
    tick();
    if (instruction !== 32'h1800_5000 || pc !== 8'd1) begin $display("[TB] FAIL lin_w0: got %h pc=%h want 18005000 pc=01", instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (instruction !== 32'h5800_3000 || pc !== 8'd2) begin $display("[TB] FAIL lin_w1: got %h pc=%h want 58003000 pc=02", instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (instruction !== 32'h0 || halted !== 1'b1 || pc !== 8'd2 || running !== 1'b0) begin $display("[TB] FAIL lin_halt: got %h halted=%b run=%b pc=%h want 0 halted=1 run=0 pc=02", instruction, halted, running, pc); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_branch_taken();
    loadWord(8'h05, 32'h3300_0010);
    loadWord(8'h06, HALT_W);
    loadWord(8'h10, 32'h1234_5678);
    loadWord(8'h11, HALT_W);
    psr = 5'b00100;
    startAt(8'h05);
    tick();
    if (branch_taken !== 1'b1 || instruction !== 32'h0 || pc !== 8'h05 || running !== 1'b1) begin $display("[TB] FAIL bt_eval: got bt=%b instr=%h pc=%h run=%b want bt=1 instr=0 pc=05 run=1", branch_taken, instruction, pc, running); nMiscompares++; end
    nVectors++;
    tick();
    if (branch_taken !== 1'b0 || instruction !== 32'h0 || pc !== 8'h10) begin $display("[TB] FAIL bt_redir: got bt=%b instr=%h pc=%h want bt=0 instr=0 pc=10", branch_taken, instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (instruction !== 32'h1234_5678 || pc !== 8'h11) begin $display("[TB] FAIL bt_fetch: got %h pc=%h want 12345678 pc=11", instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (halted !== 1'b1 || pc !== 8'h11) begin $display("[TB] FAIL bt_halt: got halted=%b pc=%h want 1 pc=11", halted, pc); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_branch_not_taken();
    psr = 5'b11011;
    startAt(8'h05);
    tick();
    if (branch_taken !== 1'b0 || running !== 1'b1) begin $display("[TB] FAIL bnt_eval: got bt=%b run=%b want bt=0 run=1", branch_taken, running); nMiscompares++; end
    nVectors++;
    tick();
    if (pc !== 8'h06 || instruction !== 32'h0) begin $display("[TB] FAIL bnt_pc: got pc=%h instr=%h want pc=06 instr=0", pc, instruction); nMiscompares++; end
    nVectors++;
    tick();
    if (halted !== 1'b1 || pc !== 8'h06) begin $display("[TB] FAIL bnt_halt: got halted=%b pc=%h want 1 pc=06", halted, pc); nMiscompares++; end
    nVectors++;
    // Inverted even condition with even clear must redirect
    loadWord(8'h05, 32'h3B00_0010);
    psr = 5'b00000;
    startAt(8'h05);
    tick();
    if (branch_taken !== 1'b1) begin $display("[TB] FAIL binv_eval: got bt=%b want 1", branch_taken); nMiscompares++; end
    nVectors++;
    tick();
    if (pc !== 8'h10) begin $display("[TB] FAIL binv_pc: got pc=%h want 10", pc); nMiscompares++; end
    nVectors++;
    tick();
    tick();
    if (halted !== 1'b1) begin $display("[TB] FAIL binv_halt: got halted=%b want 1", halted); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_wrap_gating();
    loadWord(8'hFF, 32'h2000_0001);
    loadWord(8'h20, 32'h7000_0001);
    loadWord(8'h21, HALT_W);
    startAt(8'hFF);
    // Write and start attempts while running must both be ignored
    load_en    = 1'b1;
    load_addr  = 8'h20;
    load_data  = HALT_W;
    start      = 1'b1;
    start_addr = 8'h50;
    tick();
    if (instruction !== 32'h2000_0001 || pc !== 8'h00) begin $display("[TB] FAIL wrap_pc: got %h pc=%h want 20000001 pc=00", instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (instruction !== 32'h1800_5000 || pc !== 8'h01) begin $display("[TB] FAIL run_start_ign: got %h pc=%h want 18005000 pc=01", instruction, pc); nMiscompares++; end
    nVectors++;
    load_en = 1'b0;
    start   = 1'b0;
    tick();
    tick();
    if (halted !== 1'b1 || pc !== 8'h02) begin $display("[TB] FAIL wrap_halt: got halted=%b pc=%h want 1 pc=02", halted, pc); nMiscompares++; end
    nVectors++;
    startAt(8'h20);
    tick();
    if (instruction !== 32'h7000_0001 || pc !== 8'h21) begin $display("[TB] FAIL load_gate: got %h pc=%h want 70000001 pc=21", instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (halted !== 1'b1 || pc !== 8'h21) begin $display("[TB] FAIL gate_halt: got halted=%b pc=%h want 1 pc=21", halted, pc); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_load_start();
    loadWord(8'h31, HALT_W);
    load_en    = 1'b1;
    load_addr  = 8'h30;
    load_data  = 32'h4000_00AA;
    start      = 1'b1;
    start_addr = 8'h30;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    tick();
    if (instruction !== 32'h4000_00AA || pc !== 8'h31) begin $display("[TB] FAIL load_start: got %h pc=%h want 400000AA pc=31", instruction, pc); nMiscompares++; end
    nVectors++;
    tick();
    if (halted !== 1'b1) begin $display("[TB] FAIL ls_halt: got halted=%b want 1", halted); nMiscompares++; end
    nVectors++;
  endtask

  task automatic test_async_reset();
    psr = 5'b00000;
    startAt(8'h05);
    tick();
    if (running !== 1'b1 || branch_taken !== 1'b1) begin $display("[TB] FAIL ar_pre: got run=%b bt=%b want run=1 bt=1", running, branch_taken); nMiscompares++; end
    nVectors++;
    #1 reset = 1'b1;
    #1;
    if (instruction !== 32'h0 || running !== 1'b0 || pc !== 8'h00 || branch_taken !== 1'b0 || halted !== 1'b0) begin $display("[TB] FAIL ar_now: got instr=%h run=%b pc=%h bt=%b halted=%b want 0 0 00 0 0", instruction, running, pc, branch_taken, halted); nMiscompares++; end
    nVectors++;
    #1 reset = 1'b0;
    tick();
    if (running !== 1'b0 || instruction !== 32'h0 || pc !== 8'h00) begin $display("[TB] FAIL ar_idle: got run=%b instr=%h pc=%h want 0 0 00", running, instruction, pc); nMiscompares++; end
    nVectors++;
  endtask

`ifdef INSTR_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    logic [31:0] words [3];
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h4444_4444;
    for (int k = 0; k < 3; k++) loadWord(PC_W'(8'h60 + k), words[k]);
    loadWord(8'h63, HALT_W);
    step_mode = 1'b1;
    step      = 1'b0;
    startAt(8'h60);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      if (instruction !== words[k] || pc !== PC_W'(8'h61 + k)) begin $display("[TB] FAIL step_issue%0d: got %h pc=%h want %h pc=%h", k, instruction, pc, words[k], PC_W'(8'h61 + k)); nMiscompares++; end
      nVectors++;
      for (int g = 0; g < 3; g++) begin
        tick();
        if (instruction !== 32'h0 || pc !== PC_W'(8'h61 + k)) begin $display("[TB] FAIL step_gap%0d: got %h pc=%h want 0 pc=%h", k, instruction, pc, PC_W'(8'h61 + k)); nMiscompares++; end
        nVectors++;
      end
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    if (halted !== 1'b1 || pc !== 8'h63) begin $display("[TB] FAIL step_halt: got halted=%b pc=%h want 1 pc=63", halted, pc); nMiscompares++; end
    nVectors++;
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    start        = 1'b0;
    start_addr   = '0;
    load_en      = 1'b0;
    load_addr    = '0;
    load_data    = '0;
    psr          = '0;
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    step         = 1'b0;
    step_mode    = 1'b0;
`endif
    test_reset();
    test_linear();
    test_branch_taken();
    test_branch_not_taken();
    test_wrap_gating();
    test_load_start();
    test_async_reset();
`ifdef INSTR_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/sequencing controller for the 12-bit processor datapath.
- Holds a program memory and a program counter, and drives the processor's 32-bit `instruction` input one word per clock.
- Resolves BRANCH (opcode 3) internally against the processor's 5-bit `psr`.
- Stops on HALT (opcode 8) until restarted.

Parameters:
- PC_W, 8, program-counter / program-memory address width.
- DEPTH, 256, program-memory words (2**PC_W).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse; begin execution at start_addr (honoured in IDLE/HALTED only)
- start_addr  input  PC_W  first fetch address
- load_en  input  1  program-memory write strobe (honoured in IDLE/HALTED only)
- load_addr  input  PC_W  write address
- load_data  input  32  instruction word to write
- psr  input  5  processor status: [0] carry, [1] parity, [2] even, [3] negative, [4] odd
- instruction  output  32  registered word issued to the processor
- pc  output  PC_W  current fetch address
- running  output  1  high in RUN or BR_EVAL
- halted  output  1  high in HALTED
- branch_taken  output  1  one-cycle pulse when a branch redirects pc

Behaviour:
- Reset (async, immediate, including mid-run or mid-branch):
  - instruction=0 (NOP), pc=0, state=IDLE.
  - running, halted and branch_taken all 0.
  - Program memory is not cleared.
- States:
  - IDLE: instruction=NOP. On start: pc<=start_addr, go to RUN.
  - RUN: each edge, word W=mem[pc] is examined.
    - W[31:28]=3 (BRANCH): instruction<=NOP, latch W[27:24] and W[PC_W-1:0], go to BR_EVAL. pc holds.
    - W[31:28]=8 (HALT): instruction<=NOP, go to HALTED. pc holds and points at the HALT word.
    - Otherwise: instruction<=W, pc<=pc+1.
  - BR_EVAL: evaluate the condition on the current psr, which reflects the last non-branch instruction because the inserted NOP leaves psr untouched.
    - Taken: pc<=target, branch_taken=1 for this cycle.
    - Not taken: pc<=pc+1.
    - instruction<=NOP, return to RUN.
    - A branch therefore costs 2 cycles, and 2 NOPs appear on `instruction`.
  - HALTED: instruction=NOP, halted=1. On start: pc<=start_addr, go to RUN.
- Condition code CC=W[27:24]:
  - CC[2:0] selects the condition: 0 always; 1 carry psr[0]; 2 parity psr[1]; 3 even psr[2]; 4 negative psr[3]; 5 odd psr[4]; 6 and 7 never.
  - CC[3]=1 inverts the selected condition, so CC=8 means never.
- Target is W[11:0] truncated to PC_W bits; upper bits are ignored.
- pc+1 wraps from DEPTH-1 to 0.
- Loading:
  - Write occurs at the edge where load_en=1 and state is IDLE or HALTED.
  - Ignored in RUN and BR_EVAL.
  - If load and start occur in the same cycle, the write completes and is visible to the first fetch.
- start in RUN or BR_EVAL is ignored.
- Instructions with opcodes other than 3 and 8, including unknown opcodes, are passed through unchanged.

Optional Feature:
- Macro: INSTR_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input `step` (1 bit) and input `step_mode` (1 bit).
  - When step_mode=1, RUN advances (issue, branch or halt decision) only on edges where step=1; otherwise instruction<=NOP and pc holds.
  - BR_EVAL completes unconditionally.
- Undefined: ports are absent and RUN advances every cycle.

Decomposition:
- Package seq_pkg:
  - Opcode constants OP_NOP=0, OP_BRANCH=3, OP_HALT=8.
  - CC select constants.
  - State enum IDLE/RUN/BR_EVAL/HALTED.
  - Instruction field bit positions.
- Sub-module seq_cond_eval: combinational (cc[3:0], psr[4:0]) -> take. Isolated so it can be verified exhaustively.

Test Plan:
- Linear issue: load 0x1800_5000, 0x5800_3000, 0x8000_0000 at addresses 0..2; start_addr=0.
  - instruction shows 0x18005000 then 0x58003000 on consecutive cycles, then NOP.
  - halted=1 with pc=2.
- Branch taken: psr[2]=1, load 0x3300_0010 (CC=3 even, target 0x10) at addr 5.
  - 2 NOPs issued, branch_taken pulses in BR_EVAL, next fetch is from pc=0x10.
- Branch not taken: same word with psr[2]=0 -> pc=6 after 2 cycles, branch_taken stays 0.
  - Repeat with CC=0xB (inverted even) -> taken.
- Wrap and gating: start_addr=255 with a non-branch word -> next pc=0.
  - load_en asserted during RUN leaves memory unchanged (read back after halt).
- Async reset mid-BR_EVAL -> instruction=0, state IDLE, running=0 immediately, without waiting for a clock edge.
- With INSTR_SEQ_SINGLE_STEP_EN and step_mode=1: 3 step pulses spaced 4 cycles apart -> exactly 3 instructions issued, NOPs in between.
